// File: rtl/gray_enc_pkg.sv
// Shared types and constants for the BCD-pair to Gray-code encoder.
package gray_enc_pkg;

  localparam int BCD_W     = 4;
  localparam int BIN_W     = 4;
  localparam int MAX_VALUE = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ENC  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-reflected Gray encoder for the ENC stage.
module bin_to_gray
  import gray_enc_pkg::*;
(
  input  logic [BIN_W-1:0] bin,
  output logic [BIN_W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/bcd_to_gray_encoder.sv
// Converts a two-digit BCD pair (0..15) to binary and Gray code through a
// four-state pipeline, with a saturating count of out-of-range pairs.
module bcd_to_gray_encoder
  import gray_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BCD_W-1:0]     bcd_tens,
  input  logic [BCD_W-1:0]     bcd_units,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     binary_code,
  output logic [BIN_W-1:0]     gray_code,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output state_t               dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid & ready are
  // both 1; the producer holds valid and data stable until that edge.
  state_t           state, state_nxt;
  logic [BCD_W-1:0] tens_q, units_q;
  logic [BIN_W-1:0] bin_q;
  logic             range_err_q;
  logic [4:0]       sum5;
  logic             range_err;
  logic [BIN_W-1:0] gray_enc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  // tens*8 + tens*2 + units; only meaningful once tens <= 1 and units <= 9.
  always_comb begin
    sum5      = 5'({tens_q, 3'b000}) + 5'({tens_q, 1'b0}) + 5'(units_q);
    range_err = (tens_q > 4'd1) || (units_q > 4'd9) || (sum5 > 5'(MAX_VALUE));
  end

  bin_to_gray u_bin_to_gray (
    .bin  (bin_q),
    .gray (gray_enc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    state_nxt = ENC;
      ENC:     state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q      <= '0;
      units_q     <= '0;
      bin_q       <= '0;
      range_err_q <= 1'b0;
      binary_code <= '0;
      gray_code   <= '0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tens_q  <= bcd_tens;
            units_q <= bcd_units;
          end
        end
        CONV: begin
          bin_q       <= range_err ? '0 : sum5[BIN_W-1:0];
          range_err_q <= range_err;
        end
        ENC: begin
          binary_code <= bin_q;
          gray_code   <= range_err_q ? '0 : gray_enc;
          err         <= range_err_q;
          if (range_err_q && (err_count != {ERR_CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_gray_encoder.sv
// Bench for bcd_to_gray_encoder: vector table, hand-written corner sequences
// and random pairs, all checked through an expected-result queue.
module tb_bcd_to_gray_encoder;
  import gray_enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] bcd_tens, bcd_units;
  logic       in_ready, out_valid, err;
  logic [3:0] binary_code, gray_code;
  logic [7:0] err_count;
  state_t     dbg_state;
  logic       in_ready_s, out_valid_s, err_s;
  logic [3:0] binary_code_s, gray_code_s;
  logic [1:0] err_count_s;
  state_t     dbg_state_s;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       err;
  } vec_t;

  vec_t       vecs[11];
  logic [8:0] exp_q[$];   // {err, binary, gray}
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;

  always #5 clk = ~clk;

  bcd_to_gray_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units), .out_valid(out_valid),
    .out_ready(out_ready), .binary_code(binary_code), .gray_code(gray_code),
    .err(err), .err_count(err_count), .dbg_state(dbg_state)
  );

  bcd_to_gray_encoder #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units), .out_valid(out_valid_s),
    .out_ready(out_ready), .binary_code(binary_code_s), .gray_code(gray_code_s),
    .err(err_s), .err_count(err_count_s), .dbg_state(dbg_state_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input int t, input int u);
    logic [3:0] b, g;
    if (t > 1 || u > 9 || (t * 10 + u) > 15) return {1'b1, 8'h00};
    b = 4'(t * 10 + u);
    g = {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    return {1'b0, b, g};
  endfunction

  // Caller sits just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [3:0] t, input logic [3:0] u, input logic [8:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    bcd_tens  = t;
    bcd_units = u;
    in_valid  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    bcd_tens  = 4'($urandom);
    bcd_units = 4'($urandom);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[8]) err_seen++;
        check("err", {31'd0, err}, {31'd0, e[8]});
        check("binary_code", {28'd0, binary_code}, {28'd0, e[7:4]});
        check("gray_code", {28'd0, gray_code}, {28'd0, e[3:0]});
        check("err_count", {24'd0, err_count}, (err_seen > 255) ? 255 : err_seen);
        check("err_count_w2", {30'd0, err_count_s}, (err_seen > 3) ? 3 : err_seen);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd1,  4'd2,  4'b1100, 4'b1010, 1'b0};
    vecs[1]  = '{4'd0,  4'd9,  4'b1001, 4'b1101, 1'b0};
    vecs[2]  = '{4'd1,  4'd5,  4'b1111, 4'b1000, 1'b0};
    vecs[3]  = '{4'd1,  4'd6,  4'b0000, 4'b0000, 1'b1};
    vecs[4]  = '{4'd0,  4'd10, 4'b0000, 4'b0000, 1'b1};
    vecs[5]  = '{4'd0,  4'd0,  4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{4'd1,  4'd0,  4'b1010, 4'b1111, 1'b0};
    vecs[7]  = '{4'd2,  4'd0,  4'b0000, 4'b0000, 1'b1};
    vecs[8]  = '{4'd9,  4'd9,  4'b0000, 4'b0000, 1'b1};
    vecs[9]  = '{4'd0,  4'd7,  4'b0111, 4'b0100, 1'b0};
    vecs[10] = '{4'd15, 4'd15, 4'b0000, 4'b0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    bcd_tens = 4'd0; bcd_units = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_binary", {28'd0, binary_code}, 32'd0);
    check("rst_gray", {28'd0, gray_code}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;

    // Latency: result appears two edges after the transfer edge.
    out_ready = 1'b1;
    send(4'd1, 4'd2, {1'b0, 4'b1100, 4'b1010});
    check("lat_state_conv", {30'd0, dbg_state}, {30'd0, CONV});
    check("lat_valid_e0", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_e1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_e2", {31'd0, out_valid}, 32'd1);
    check("lat_binary", {28'd0, binary_code}, 32'b1100);
    check("lat_gray", {28'd0, gray_code}, 32'b1010);
    drain(1'b0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].tens, vecs[i].units, {vecs[i].err, vecs[i].bin, vecs[i].gray});
      drain(1'b0);
    end
    check("sat_err_count_w2", {30'd0, err_count_s}, 32'd3);
    check("err_count_w8", {24'd0, err_count}, 32'd5);

    // Downstream stall: outputs frozen, new input ignored.
    out_ready = 1'b0;
    send(4'd0, 4'd9, {1'b0, 4'b1001, 4'b1101});
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; bcd_tens = 4'd1; bcd_units = 4'd3;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_binary", {28'd0, binary_code}, 32'b1001);
      check("stall_gray", {28'd0, gray_code}, 32'b1101);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_binary_kept", {28'd0, binary_code}, 32'b1001);
    check("release_queue", exp_q.size(), 0);

    // Asynchronous reset while a pair is in CONV.
    send(4'd1, 4'd6, model(1, 6));
    check("pre_rst_state", {30'd0, dbg_state}, {30'd0, CONV});
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_err_count", {24'd0, err_count}, 32'd0);
    check("arst_err_count_w2", {30'd0, err_count_s}, 32'd0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    err_seen = 0;
    send(4'd1, 4'd3, model(1, 3));
    drain(1'b0);

    for (int i = 0; i < 40; i++) begin
      int t, u;
      t = $urandom_range(0, 2);
      u = $urandom_range(0, 11);
      send(4'(t), 4'(u), model(t, u));
      drain(1'b1);
    end

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_gray_encoder.md
BCD_TO_GRAY_ENCODER -- requirements
Module: bcd_to_gray_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  BCD pair on bcd_tens/bcd_units is valid.
REQ-005 in_ready  output  1  block can accept a BCD pair.
REQ-006 bcd_tens  input  4  BCD tens digit.
REQ-007 bcd_units  input  4  BCD units digit.
REQ-008 out_valid  output  1  result on binary_code/gray_code/err is valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 binary_code  output  4  binary value of the accepted pair.
REQ-011 gray_code  output  4  Gray code of binary_code.
REQ-012 err  output  1  accepted pair was out of range.
REQ-013 err_count  output  ERR_CNT_W  number of errored results produced, saturating.

Function
REQ-014 The FSM SHALL have the states IDLE, CONV, ENC and HOLD.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with in_valid & in_ready; the digits are captured into internal registers.
REQ-016 On an input transfer the state SHALL move IDLE->CONV; with no transfer it SHALL stay in IDLE.
REQ-017 CONV SHALL last one cycle: it registers binary = tens*10 + units (tens*8 + tens*2 + units, 5-bit intermediate) and range-check flag, then moves to ENC.
REQ-018 The pair SHALL be out of range if tens > 1, units > 9, or tens == 1 with units > 5; binary_code is 0 and err is 1 in that case.
REQ-019 ENC SHALL last one cycle: it registers gray_code = binary ^ (binary >> 1) (0 when err), sets out_valid, and moves to HOLD.
REQ-020 Latency: out_valid SHALL rise two edges after the input-transfer edge.
REQ-021 In HOLD, out_valid, binary_code, gray_code and err SHALL stay stable until an edge with out_ready = 1.
REQ-022 On that edge the state SHALL return to IDLE and out_valid SHALL drop; the outputs keep their last values.
REQ-023 in_ready SHALL be 0 in CONV, ENC and HOLD; input changes in those states are ignored.
REQ-024 out_ready asserted outside HOLD SHALL have no effect.
REQ-025 err_count SHALL increment on the ENC->HOLD edge when err is 1, and SHALL saturate at all-ones without wrapping.
REQ-026 Throughput: at most one result per 4 cycles (back-to-back with out_ready held at 1).

Reset
REQ-027 rst SHALL force IDLE immediately, asynchronously, from any state, discarding any conversion in flight.
REQ-028 Reset values: in_ready=1 (once in IDLE), out_valid=0, binary_code=0, gray_code=0, err=0, err_count=0.
REQ-029 After rst deasserts, the first rising clock edge SHALL be able to accept a transfer.

Structure
REQ-030 The package gray_enc_pkg SHALL hold the state enum (IDLE, CONV, ENC, HOLD), MAX_VALUE=15, BCD_W=4 and BIN_W=4.
REQ-031 The combinational sub-module bin_to_gray (4-bit binary in, 4-bit Gray out) SHALL be instantiated for the ENC stage.

Verification
REQ-032 tens=1, units=2, out_ready=1 -> after 2 edges binary_code=1100, gray_code=1010, err=0.
REQ-033 tens=0, units=9 -> binary_code=1001, gray_code=1101; tens=1, units=5 -> binary_code=1111, gray_code=1000.
REQ-034 tens=1, units=6, then tens=0, units=10 -> err=1, gray_code=0000 on both, err_count=2.
REQ-035 out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst pulse mid-CONV -> out_valid=0, in_ready=1, err_count=0; the next pair converts correctly.
REQ-037 ERR_CNT_W=2 with 5 errored pairs -> err_count saturates at 11.
